// File: rtl/exe_pkg.sv
// Shared types for the execution-stage writeback path: completion and WB records,
// default sizing, and the round-robin pointer step.
package exe_pkg;
  localparam int NUM_UNITS_DEF = 4;
  localparam int DATA_W_DEF    = 64;
  localparam int REG_W_DEF     = 5;
  localparam int UNIT_W_DEF    = $clog2(NUM_UNITS_DEF);

  typedef enum logic [UNIT_W_DEF-1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_DIV = 2'd2,
    UNIT_MEM = 2'd3
  } unit_e;

  typedef struct packed {
    logic [REG_W_DEF-1:0]  rd;
    logic [DATA_W_DEF-1:0] data;
    logic                  xcpt;
  } cmpl_t;

  typedef struct packed {
    logic                  valid;
    unit_e                 unit;
    logic [REG_W_DEF-1:0]  rd;
    logic [DATA_W_DEF-1:0] data;
    logic                  xcpt;
  } wb_t;

  function automatic int rr_next(input int g, input int n);
    return (g + 1 == n) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/exe_wb_arbiter.sv
// Completion buffer and writeback arbiter: one holding register per functional
// unit, round-robin retirement into a registered WB port, forwarding and hazard.
module exe_wb_arbiter
  import exe_pkg::*;
#(
  parameter int NUM_UNITS = NUM_UNITS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_W     = REG_W_DEF,
  parameter int UNIT_W    = $clog2(NUM_UNITS)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                kill_i,
  input  logic [NUM_UNITS-1:0]                done_i,
  input  logic [NUM_UNITS-1:0][REG_W-1:0]     done_rd_i,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]    done_data_i,
  input  logic [NUM_UNITS-1:0]                done_xcpt_i,
  output logic [NUM_UNITS-1:0]                unit_ready_o,
  output logic                                wb_valid_o,
  output logic [UNIT_W-1:0]                   wb_unit_o,
  output logic [REG_W-1:0]                    wb_rd_o,
  output logic [DATA_W-1:0]                   wb_data_o,
  output logic                                wb_xcpt_o,
  input  logic [REG_W-1:0]                    rs1_idx_i,
  input  logic [REG_W-1:0]                    rs2_idx_i,
  input  logic [DATA_W-1:0]                   rs1_data_i,
  input  logic [DATA_W-1:0]                   rs2_data_i,
  output logic [DATA_W-1:0]                   rs1_fwd_o,
  output logic [DATA_W-1:0]                   rs2_fwd_o,
  output logic                                hazard_o,
  output logic                                busy_o
);
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic              xcpt;
  } rec_t;

  logic [NUM_UNITS-1:0] hold_valid_q, hold_valid_d;
  rec_t [NUM_UNITS-1:0] hold_q, hold_d;
  rec_t [NUM_UNITS-1:0] offer;
  logic [UNIT_W-1:0]    ptr_q, ptr_d;
  logic [NUM_UNITS-1:0] req, grant;
  logic [UNIT_W-1:0]    gidx;
  rec_t                 win;
  logic                 retire;

  logic                 wb_valid_q;
  logic [UNIT_W-1:0]    wb_unit_q;
  logic [REG_W-1:0]     wb_rd_q;
  logic [DATA_W-1:0]    wb_data_q;
  logic                 wb_xcpt_q;

  always_comb begin
    offer = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      offer[i] = '{rd: done_rd_i[i], data: done_data_i[i], xcpt: done_xcpt_i[i]};
  end

  assign req = hold_valid_q | done_i;

  rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // A kill cycle swallows every offered result, so all units see ready.
  assign unit_ready_o = kill_i ? '1 : (~hold_valid_q | grant);
  assign retire       = (|grant) & ~kill_i;

  always_comb begin
    gidx = '0;
    win  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (grant[i]) begin
        gidx = UNIT_W'(i);
        win  = hold_valid_q[i] ? hold_q[i] : offer[i];
      end
    end
  end

  // A new result lands in hold unless it bypasses straight to WB (empty hold + grant).
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (kill_i) begin
        hold_valid_d[i] = 1'b0;
      end else if (done_i[i] && unit_ready_o[i] && (hold_valid_q[i] || !grant[i])) begin
        hold_valid_d[i] = 1'b1;
        hold_d[i]       = offer[i];
      end else if (grant[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
  end

  assign ptr_d = retire ? UNIT_W'(rr_next(int'(gidx), NUM_UNITS)) : ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid_q <= '0;
      ptr_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_unit_q    <= '0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_xcpt_q    <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      ptr_q        <= ptr_d;
      wb_valid_q   <= retire;
      if (retire) begin
        wb_unit_q <= gidx;
        wb_rd_q   <= win.rd;
        wb_data_q <= win.data;
        wb_xcpt_q <= win.xcpt;
      end
    end
  end

  // Payload is qualified by hold_valid_q, so it needs no reset.
  always_ff @(posedge clk_i) hold_q <= hold_d;

  assign wb_valid_o = wb_valid_q;
  assign wb_unit_o  = wb_unit_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign wb_xcpt_o  = wb_xcpt_q;

  assign rs1_fwd_o = (wb_valid_q && !wb_xcpt_q && rs1_idx_i != '0 && rs1_idx_i == wb_rd_q)
                     ? wb_data_q : rs1_data_i;
  assign rs2_fwd_o = (wb_valid_q && !wb_xcpt_q && rs2_idx_i != '0 && rs2_idx_i == wb_rd_q)
                     ? wb_data_q : rs2_data_i;

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (hold_valid_q[i] && hold_q[i].rd != '0 &&
          (hold_q[i].rd == rs1_idx_i || hold_q[i].rd == rs2_idx_i))
        hazard_o = 1'b1;
  end

  assign busy_o = |hold_valid_q;
endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Scoreboard bench for exe_wb_arbiter: directed scenarios plus randomized traffic,
// checked against a per-unit queue model of the completion buffer.
module tb_exe_wb_arbiter;
  import exe_pkg::*;
  localparam int N = NUM_UNITS_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int RW = REG_W_DEF;
  localparam int UW = UNIT_W_DEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, kill;
  logic [N-1:0]         done, done_xcpt, unit_ready;
  logic [N-1:0][RW-1:0] done_rd;
  logic [N-1:0][DW-1:0] done_data;
  logic                 wb_valid, wb_xcpt, hazard, busy;
  logic [UW-1:0]        wb_unit;
  logic [RW-1:0]        wb_rd, rs1_idx, rs2_idx;
  logic [DW-1:0]        wb_data, rs1_data, rs2_data, rs1_fwd, rs2_fwd;

  exe_wb_arbiter dut (
    .clk_i(clk), .rst_i(rst), .kill_i(kill),
    .done_i(done), .done_rd_i(done_rd), .done_data_i(done_data), .done_xcpt_i(done_xcpt),
    .unit_ready_o(unit_ready),
    .wb_valid_o(wb_valid), .wb_unit_o(wb_unit), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .wb_xcpt_o(wb_xcpt),
    .rs1_idx_i(rs1_idx), .rs2_idx_i(rs2_idx), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .rs1_fwd_o(rs1_fwd), .rs2_fwd_o(rs2_fwd), .hazard_o(hazard), .busy_o(busy)
  );

  typedef struct {
    wb_t w;
    bit  is_rst;
  } exp_t;

  int    tests = 0;
  int    fails = 0;
  int    rate  = 100;
  cmpl_t src[N][$];   // results each unit still has to offer
  cmpl_t mq[N][$];    // model: results the buffer currently owns per unit
  exp_t  expq[$];
  int    mptr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cmpl_t rnd_rec();
    cmpl_t c;
    c.rd   = RW'($urandom_range(0, 7));
    c.data = {$urandom, $urandom};
    c.xcpt = ($urandom_range(0, 9) == 0);
    return c;
  endfunction

  function automatic cmpl_t mk(input int rd, input logic [63:0] data);
    cmpl_t c;
    c.rd = RW'(rd); c.data = data; c.xcpt = 1'b0;
    return c;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Unit-side drivers: offer the next result and hold it until accepted.
  initial begin
    logic [N-1:0] acc;
    done = '0; done_rd = '0; done_data = '0; done_xcpt = '0;
    rs1_idx = '0; rs2_idx = '0; rs1_data = '0; rs2_data = '0;
    forever begin
      @(negedge clk);
      acc = done & unit_ready;
      @(posedge clk); #1;
      for (int u = 0; u < N; u++) begin
        if (acc[u]) done[u] = 1'b0;
        if (!done[u] && src[u].size() != 0 && $urandom_range(0, 99) < rate) begin
          cmpl_t c;
          c = src[u].pop_front();
          done[u] = 1'b1; done_rd[u] = c.rd; done_data[u] = c.data; done_xcpt[u] = c.xcpt;
        end
      end
      rs1_idx = RW'($urandom_range(0, 7)); rs2_idx = RW'($urandom_range(0, 7));
      rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
    end
  end

  // Reference model: each unit owns a queue of buffered results; every cycle the
  // first unit with anything to retire, scanning from the rotating start, goes to WB.
  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] hv, req, exp_ready;
    logic         exp_haz;
    int           g;
    e = '{w: '0, is_rst: 1'b0};
    if (rst) begin
      for (int u = 0; u < N; u++) mq[u].delete();
      mptr = 0;
      e.is_rst = 1'b1;
      expq.push_back(e);
    end else begin
      exp_haz = 1'b0;
      for (int u = 0; u < N; u++) begin
        hv[u] = (mq[u].size() != 0);
        foreach (mq[u][k])
          if (mq[u][k].rd != 0 && (mq[u][k].rd == rs1_idx || mq[u][k].rd == rs2_idx))
            exp_haz = 1'b1;
      end
      chk("busy", 64'(busy), 64'(|hv));
      chk("hazard", 64'(hazard), 64'(exp_haz));
      req = hv | done;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req[(mptr + k) % N]) g = (mptr + k) % N;
      exp_ready = ~hv;
      if (g >= 0) exp_ready[g] = 1'b1;
      if (kill) exp_ready = '1;
      chk("unit_ready", 64'(unit_ready), 64'(exp_ready));
      if (kill) begin
        for (int u = 0; u < N; u++) mq[u].delete();
      end else begin
        if (g >= 0) begin
          cmpl_t r;
          if (hv[g]) r = mq[g].pop_front();
          else       r = '{rd: done_rd[g], data: done_data[g], xcpt: done_xcpt[g]};
          e.w.valid = 1'b1; e.w.unit = unit_e'(g);
          e.w.rd = r.rd; e.w.data = r.data; e.w.xcpt = r.xcpt;
          mptr = (g + 1) % N;
        end
        for (int u = 0; u < N; u++)
          if (done[u] && exp_ready[u] && !(u == g && !hv[u]))
            mq[u].push_back('{rd: done_rd[u], data: done_data[u], xcpt: done_xcpt[u]});
      end
      expq.push_back(e);
    end
  end

  // Monitor: one expected WB record per cycle, compared just after the edge.
  initial begin
    forever begin
      exp_t e;
      logic [DW-1:0] f1, f2;
      @(posedge clk); #2;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("wb_valid", 64'(wb_valid), 64'(e.w.valid));
        if (e.is_rst) begin
          chk("rst_wb_fields", {wb_xcpt, wb_unit, wb_rd, wb_data[15:0]}, 64'd0);
          chk("rst_wb_data", wb_data, 64'd0);
        end else if (e.w.valid) begin
          chk("wb_unit", 64'(wb_unit), 64'(e.w.unit));
          chk("wb_rd", 64'(wb_rd), 64'(e.w.rd));
          chk("wb_data", wb_data, e.w.data);
          chk("wb_xcpt", 64'(wb_xcpt), 64'(e.w.xcpt));
        end
        f1 = (e.w.valid && !e.w.xcpt && rs1_idx != 0 && rs1_idx == e.w.rd) ? e.w.data : rs1_data;
        f2 = (e.w.valid && !e.w.xcpt && rs2_idx != 0 && rs2_idx == e.w.rd) ? e.w.data : rs2_data;
        chk("rs1_fwd", rs1_fwd, f1);
        chk("rs2_fwd", rs2_fwd, f2);
      end
    end
  end

  function automatic bit pending();
    bit p = (done != '0);
    for (int u = 0; u < N; u++) if (src[u].size() != 0 || mq[u].size() != 0) p = 1'b1;
    return p;
  endfunction

  initial begin
    rst = 1'b1; kill = 1'b0; rate = 100;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(2);
    // single result from unit 1
    src[1].push_back(mk(7, 64'hDEAD));
    cyc(4);
    // contention from pointer 0
    rst = 1'b1; cyc(1); rst = 1'b0;
    for (int u = 0; u < N; u++) src[u].push_back(mk(u + 1, 64'h100 + u));
    cyc(8);
    // fairness: unit 0 streams, unit 2 once
    for (int k = 0; k < 6; k++) src[0].push_back(mk(5, 64'h11));
    src[2].push_back(mk(9, 64'h22));
    cyc(10);
    // kill with held entries and a fresh offer
    for (int u = 0; u < N; u++) src[u].push_back(mk(u + 2, 64'h200 + u));
    cyc(2);
    src[0].push_back(mk(3, 64'h3333));
    kill = 1'b1; cyc(1); kill = 1'b0;
    cyc(6);
    // reset with three held entries
    for (int u = 0; u < N; u++) src[u].push_back(mk(u + 4, 64'h300 + u));
    cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    src[3].push_back(mk(6, 64'h44)); src[0].push_back(mk(8, 64'h55));
    cyc(8);
    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rate = $urandom_range(30, 100);
      for (int u = 0; u < N; u++)
        if (src[u].size() < 2 && $urandom_range(0, 3) == 0) src[u].push_back(rnd_rec());
      kill = ($urandom_range(0, 99) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    kill = 1'b0; rst = 1'b0; rate = 100;
    begin
      int n = 0;
      while (pending() && n < 300) begin cyc(1); n++; end
      tests++;
      if (pending()) begin
        fails++;
        $display("FAIL drain: got pending work after %0d cycles expected none", n);
      end
    end
    cyc(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
